// File: rtl/mem_arbiter_if.sv
`default_nettype none
// mem_arbiter_if: requester (IF/DM), halt control and memory-side signals of mem_arbiter.
// slave is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_done;
   logic [15:0] if_rdata;
   logic        if_stall;
   logic        dm_req;
   logic        dm_wr;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic        dm_done;
   logic [15:0] dm_rdata;
   logic        dm_stall;
   logic        halt;
   logic        halted;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_dump;

   modport slave (
      input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
      output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall, halted,
             mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
   );

   modport master (
      output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
      input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall, halted,
             mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one single-port memory between IF and DM with fixed DM priority,
// an IF starvation guard, fixed-latency sequencing, and drain-then-dump on halt.
module mem_arbiter #(
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] C_LAT = CNT_W'(LATENCY);
   localparam logic [STV_W-1:0] C_STV = STV_W'(STARVE_MAX);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_DUMP, S_HALTED} state_t;
   typedef enum logic [1:0] {G_NONE, G_IF, G_DM} grant_t;

   state_t           state_q, state_d;
   grant_t           grant_q, grant_d;
   logic             wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic [15:0]      if_rdata_q, if_rdata_d;
   logic [15:0]      dm_rdata_q, dm_rdata_d;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      wr_d          = wr_q;
      cnt_d         = cnt_q;
      starve_d      = starve_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_dump  = 1'b0;
      bus.if_done   = 1'b0;
      bus.dm_done   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.halt) begin
               state_d = S_DUMP;
            end else if (bus.dm_req && !(starve_q == C_STV && bus.if_req)) begin
               bus.mem_en    = 1'b1;
               bus.mem_wr    = bus.dm_wr;
               bus.mem_addr  = bus.dm_addr;
               bus.mem_wdata = bus.dm_wr ? bus.dm_wdata : 16'h0000;
               grant_d       = G_DM;
               wr_d          = bus.dm_wr;
               cnt_d         = CNT_W'(1);
               state_d       = S_WAIT;
               if (bus.if_req && starve_q != C_STV) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (bus.if_req) begin
               bus.mem_en   = 1'b1;
               bus.mem_addr = bus.if_addr;
               grant_d      = G_IF;
               wr_d         = 1'b0;
               cnt_d        = CNT_W'(1);
               starve_d     = '0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            // mem_rdata is only valid in the cycle the count reaches the latency
            if (cnt_q == C_LAT) begin
               if (grant_q == G_IF) begin
                  if_rdata_d = bus.mem_rdata;
               end else if (grant_q == G_DM && !wr_q) begin
                  dm_rdata_d = bus.mem_rdata;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            bus.if_done = (grant_q == G_IF);
            bus.dm_done = (grant_q == G_DM);
            grant_d     = G_NONE;
            state_d     = bus.halt ? S_DUMP : S_IDLE;
         end
         S_DUMP: begin
            bus.mem_dump = 1'b1;
            state_d      = S_HALTED;
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= G_NONE;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign bus.if_rdata = if_rdata_q;
   assign bus.dm_rdata = dm_rdata_q;
   assign bus.if_stall = bus.if_req & ~bus.if_done;
   assign bus.dm_stall = bus.dm_req & ~bus.dm_done;
   assign bus.halted   = (state_q == S_HALTED);
endmodule
`default_nettype wire
